// File: rtl/dm_com_loader_pkg.sv
// Shared types for the DM communication loader: selector status codes, FSM states
// and the byte-pair packing helper.
package dm_com_pkg;

    localparam logic [1:0] ST_COM_WR = 2'b00;
    localparam logic [1:0] ST_PROC   = 2'b01;
    localparam logic [1:0] ST_COM_RD = 2'b10;

    typedef enum logic [3:0] {
        LOAD      = 4'd0,
        RUN       = 4'd1,
        DUMP_ADDR = 4'd2,
        DUMP_CAP  = 4'd3,
        TX_LO     = 4'd4,
        TX_HI     = 4'd5,
        CK_LO     = 4'd6,
        CK_HI     = 4'd7,
        DONE      = 4'd8
    } state_t;

    function automatic logic [15:0] pack_word(input logic [7:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/dm_tx_byte_reg.sv
// Single-byte transmit hold register: a load presents a byte with valid, which stays
// asserted (byte unchanged) until the consumer's ready completes the transfer.
module dm_tx_byte_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] data_i,
    input  logic       ready_i,
    output logic       valid_o,
    output logic [7:0] byte_o
);

    logic       valid_q;
    logic [7:0] byte_q;

    // Hold register; a load in the same cycle as a completed transfer chains the next byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            byte_q  <= 8'h00;
        end else if (load_i) begin
            valid_q <= 1'b1;
            byte_q  <= data_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_q;
        end
    end

    assign valid_o = valid_q;
    assign byte_o  = byte_q;

endmodule

// File: rtl/dm_com_loader.sv
// Communication-side DM sequencer: LOAD (UART bytes -> DM words), RUN, DUMP (DM -> bytes).
// Optional trailing 16-bit checksum bytes when DM_COM_CHECKSUM_EN is defined.
module dm_com_loader
    import dm_com_pkg::*;
#(
    parameter int unsigned LOAD_WORDS = 256,
    parameter int unsigned DUMP_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_byte,
    output logic        proc_start,
    input  logic        proc_done,
    output logic [1:0]  status,
    output logic [15:0] com_addr,
    output logic [15:0] com_data_in,
    output logic        com_wr_en,
    input  logic [15:0] com_data_out
);

    localparam logic [16:0] LOAD_END = 17'(LOAD_WORDS);
    localparam logic [16:0] DUMP_END = 17'(DUMP_WORDS);

    state_t      state_q, state_d;
    logic [16:0] count_q, count_d;
    logic [7:0]  lo_q, lo_d;
    logic        phase_q, phase_d;
    logic [1:0]  status_q, status_d;
    logic [15:0] com_addr_q, com_addr_d;
    logic [15:0] com_data_in_q, com_data_in_d;
    logic        com_wr_en_q, com_wr_en_d;
    logic        proc_start_q, proc_start_d;
    logic [15:0] word_q, word_d;

    logic        tx_load_s;
    logic [7:0]  tx_data_s;
    logic        tx_valid_s;
    logic [7:0]  tx_byte_s;
    logic        tx_fire_s;
    logic [16:0] count_inc_s;
    logic        load_end_s;
    logic        run_go_s;

    assign tx_fire_s   = tx_valid_s & tx_ready;
    assign count_inc_s = count_q + 17'd1;
    // The final write cycle itself stays in LOAD so com_wr_en never overlaps status 01.
    assign load_end_s  = com_wr_en_q && (count_q == LOAD_END);
    // proc_start_q is high exactly in the first RUN cycle, where proc_done is not yet sampled.
    assign run_go_s    = !proc_start_q && proc_done;

`ifdef DM_COM_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;

    // Running checksum of dumped words, cleared on DUMP entry.
    always_comb begin
        sum_d = sum_q;
        if (state_q == RUN && run_go_s) begin
            sum_d = 16'h0000;
        end else if (state_q == DUMP_CAP) begin
            sum_d = sum_q + com_data_out;
        end else begin
            sum_d = sum_q;
        end
    end

    // Checksum register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= 16'h0000;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:      state_d = load_end_s ? RUN : LOAD;
            RUN:       state_d = run_go_s ? DUMP_ADDR : RUN;
            DUMP_ADDR: state_d = DUMP_CAP;
            DUMP_CAP:  state_d = TX_LO;
            TX_LO:     state_d = tx_fire_s ? TX_HI : TX_LO;
            TX_HI: begin
                if (!tx_fire_s) begin
                    state_d = TX_HI;
                end else if (count_inc_s == DUMP_END) begin
`ifdef DM_COM_CHECKSUM_EN
                    state_d = CK_LO;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = DUMP_ADDR;
                end
            end
`ifdef DM_COM_CHECKSUM_EN
            CK_LO:     state_d = tx_fire_s ? CK_HI : CK_LO;
            CK_HI:     state_d = tx_fire_s ? DONE : CK_HI;
`endif
            DONE:      state_d = rx_valid ? LOAD : DONE;
            default:   state_d = LOAD;
        endcase
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        count_d       = count_q;
        lo_d          = lo_q;
        phase_d       = phase_q;
        status_d      = status_q;
        com_addr_d    = com_addr_q;
        com_data_in_d = com_data_in_q;
        com_wr_en_d   = 1'b0;
        proc_start_d  = 1'b0;
        word_d        = word_q;
        tx_load_s     = 1'b0;
        tx_data_s     = 8'h00;
        case (state_q)
            LOAD: begin
                if (load_end_s) begin
                    status_d     = ST_PROC;
                    proc_start_d = 1'b1;
                end else if (rx_valid && !phase_q) begin
                    lo_d    = rx_byte;
                    phase_d = 1'b1;
                end else if (rx_valid) begin
                    com_wr_en_d   = 1'b1;
                    com_data_in_d = pack_word(rx_byte, lo_q);
                    com_addr_d    = count_q[15:0];
                    count_d       = count_inc_s;
                    phase_d       = 1'b0;
                end else begin
                    phase_d = phase_q;
                end
            end
            RUN: begin
                if (run_go_s) begin
                    status_d   = ST_COM_RD;
                    com_addr_d = 16'h0000;
                    count_d    = 17'd0;
                end else begin
                    status_d = status_q;
                end
            end
            DUMP_CAP: begin
                word_d    = com_data_out;
                tx_load_s = 1'b1;
                tx_data_s = com_data_out[7:0];
            end
            TX_LO: begin
                if (tx_fire_s) begin
                    tx_load_s = 1'b1;
                    tx_data_s = word_q[15:8];
                end else begin
                    tx_load_s = 1'b0;
                end
            end
            TX_HI: begin
                if (tx_fire_s) begin
                    count_d = count_inc_s;
                    if (count_inc_s == DUMP_END) begin
`ifdef DM_COM_CHECKSUM_EN
                        tx_load_s = 1'b1;
                        tx_data_s = sum_q[7:0];
`else
                        tx_load_s = 1'b0;
`endif
                    end else begin
                        com_addr_d = count_inc_s[15:0];
                    end
                end else begin
                    count_d = count_q;
                end
            end
`ifdef DM_COM_CHECKSUM_EN
            CK_LO: begin
                if (tx_fire_s) begin
                    tx_load_s = 1'b1;
                    tx_data_s = sum_q[15:8];
                end else begin
                    tx_load_s = 1'b0;
                end
            end
`endif
            DONE: begin
                if (rx_valid) begin
                    status_d   = ST_COM_WR;
                    count_d    = 17'd0;
                    com_addr_d = 16'h0000;
                    lo_d       = rx_byte;
                    phase_d    = 1'b1;
                end else begin
                    status_d = status_q;
                end
            end
            default: begin
                status_d = status_q;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q       <= 17'd0;
            lo_q          <= 8'h00;
            phase_q       <= 1'b0;
            status_q      <= ST_COM_WR;
            com_addr_q    <= 16'h0000;
            com_data_in_q <= 16'h0000;
            com_wr_en_q   <= 1'b0;
            proc_start_q  <= 1'b0;
            word_q        <= 16'h0000;
        end else begin
            count_q       <= count_d;
            lo_q          <= lo_d;
            phase_q       <= phase_d;
            status_q      <= status_d;
            com_addr_q    <= com_addr_d;
            com_data_in_q <= com_data_in_d;
            com_wr_en_q   <= com_wr_en_d;
            proc_start_q  <= proc_start_d;
            word_q        <= word_d;
        end
    end

    dm_tx_byte_reg u_tx (
        .clk     (clk),
        .rst     (rst),
        .load_i  (tx_load_s),
        .data_i  (tx_data_s),
        .ready_i (tx_ready),
        .valid_o (tx_valid_s),
        .byte_o  (tx_byte_s)
    );

    assign tx_valid    = tx_valid_s;
    assign tx_byte     = tx_byte_s;
    assign proc_start  = proc_start_q;
    assign status      = status_q;
    assign com_addr    = com_addr_q;
    assign com_data_in = com_data_in_q;
    assign com_wr_en   = com_wr_en_q;

endmodule
